execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of tiny_MIPS; sits between INSTRUCTION_DECODE (DX regs) and MEMORY stage (XM regs).
//  Performs ALU op, resolves beq/bne/j, drives PC redirect to fetch, and squashes wrong-path
//  instructions in flight behind a taken redirect. All outputs are registered (XM pipeline register).
// PARAMETERS
//  SQUASH_CNT  2  wrong-path slots squashed after a taken redirect (1..3)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  MemtoReg     in   1   DX: writeback selects memory data
//  RegWrite     in   1   DX: register write enable
//  MemRead      in   1   DX: load
//  MemWrite     in   1   DX: store
//  branch       in   1   DX: conditional branch
//  bne          in   1   DX: 1=bne, 0=beq (valid with branch)
//  jump         in   1   DX: j
//  ALUctr       in   3   DX: 0 add,1 sub,2 and,3 or,4 slt
//  JT           in   32  DX: jump target
//  NPC          in   32  DX: instruction address + 4
//  A            in   32  DX: rs value
//  B            in   32  DX: rt value or sign-extended imm (decoder-selected)
//  imm          in   16  DX: raw immediate
//  MD           in   32  DX: rt value (store data)
//  RD           in   5   DX: destination register
//  XM_MemtoReg  out  1   XM copy
//  XM_RegWrite  out  1   XM copy (0 when squashed)
//  XM_MemRead   out  1   XM copy (0 when squashed)
//  XM_MemWrite  out  1   XM copy (0 when squashed)
//  ALUout       out  32  ALU result
//  XM_MD        out  32  store data
//  XM_RD        out  5   destination register
//  redirect     out  1   1-cycle pulse: fetch must load target next edge
//  target       out  32  redirect address, valid when redirect=1
// BEHAVIOUR
//  - Reset: every output 0; FSM -> RUN; squash counter 0. Reset wins over all other events.
//  - Latency 1: DX inputs sampled at edge N appear on XM outputs after edge N.
//  - ALU (32-bit, wrap, no overflow trap): add A+B; sub A-B; and; or; slt = signed A<B ? 1:0.
//    ALUctr 5..7 -> ALUout 0.
//  - Branch: eq = (A==B). taken = branch & (bne ? !eq : eq). target = NPC + (sext(imm)<<2), mod 2^32.
//  - Jump: taken unconditionally, target = JT. jump has priority over branch if both set.
//  - Branch/jump never write regs/memory: ID supplies RegWrite=MemWrite=0 for them; EX forwards as-is.
//  - FSM: RUN / SQUASH.
//    RUN: live instr; if taken -> redirect=1, target latched, cnt<=SQUASH_CNT, go SQUASH.
//    SQUASH: incoming instr is a bubble: XM_RegWrite/MemRead/MemWrite/MemtoReg <=0, redirect<=0,
//      data outputs still update (don't-care); branch/jump on squashed slot IGNORED.
//      cnt<=cnt-1; cnt==1 at this edge -> RUN.
//  - redirect high exactly one cycle per taken redirect; never asserted in consecutive cycles.
//  - Reset mid-SQUASH: back to RUN, cnt 0, no further squash.
// STRUCTURE
//  - Shared package tiny_mips_pkg: ALUctr codes (ALU_ADD..ALU_SLT), opcode consts, SQUASH_CNT default.
//  - One sub-module: alu (combinational A,B,ALUctr -> result, eq). FSM, redirect, XM regs here.
// TESTING
//  1 rst=1 two cycles -> all outputs 0, redirect 0; release -> RUN.
//  2 add A=5 B=7 RD=3 RegWrite=1 -> next cycle ALUout=12, XM_RD=3, XM_RegWrite=1; sub 5-7 -> 0xFFFFFFFE.
//  3 slt A=0xFFFFFFFF B=1 -> ALUout=1; and/or 0xF0F0,0x0FF0 -> 0x00F0/0xFFF0; ALUctr=6 -> 0.
//  4 beq A=B=9 NPC=0x100 imm=0xFFFF -> redirect=1,target=0xFC; next 2 instrs (sw MemWrite=1) -> XM_MemWrite=0;
//    3rd instr live.
//  5 bne A=B -> no redirect, no squash; j JT=0x400 followed by j in slot 1 -> one redirect only, target 0x400.
//  6 taken branch, rst asserted in first squash cycle -> outputs 0; instr after reset passes unsquashed.

Source files
------------

// File: rtl/tiny_mips_pkg.sv
// Shared tiny_MIPS definitions: ALU control codes, opcodes, EX-stage FSM states
// and the default number of wrong-path slots squashed after a taken redirect.
package tiny_mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam int SQUASH_CNT_DEFAULT = 2;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } ex_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU for the EX stage; also reports operand equality
// for beq/bne resolution.
module alu
  import tiny_mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_ctr,
  output logic [31:0] result,
  output logic        eq
);

  assign eq = (a == b);

  // Result select; unused control codes produce zero
  always_comb begin
    result = 32'd0;
    case (alu_ctr)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// tiny_MIPS EX stage: ALU, beq/bne/j resolution, PC redirect and squashing of
// wrong-path slots; every output comes from the XM pipeline register.
module execute_stage
  import tiny_mips_pkg::*;
#(
  parameter int SQUASH_CNT = SQUASH_CNT_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic [2:0]  ALUctr,
  input  logic [31:0] JT,
  input  logic [31:0] NPC,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [15:0] imm,
  input  logic [31:0] MD,
  input  logic [4:0]  RD,
  output logic        XM_MemtoReg,
  output logic        XM_RegWrite,
  output logic        XM_MemRead,
  output logic        XM_MemWrite,
  output logic [31:0] ALUout,
  output logic [31:0] XM_MD,
  output logic [4:0]  XM_RD,
  output logic        redirect,
  output logic [31:0] target
);

  localparam logic [1:0] SQ_INIT = 2'(SQUASH_CNT);

  ex_state_e   state_r;
  ex_state_e   state_nxt_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_nxt_s;
  logic        live_s;
  logic        taken_s;
  logic        eq_s;
  logic [31:0] alu_res_s;
  logic [31:0] br_tgt_s;
  logic [31:0] redir_tgt_s;

  alu u_alu (
    .a       (A),
    .b       (B),
    .alu_ctr (ALUctr),
    .result  (alu_res_s),
    .eq      (eq_s)
  );

  assign br_tgt_s = NPC + {{14{imm[15]}}, imm, 2'b00};

  // Redirect decision; jump outranks a simultaneous branch
  always_comb begin
    taken_s     = 1'b0;
    redir_tgt_s = 32'd0;
    if (jump) begin
      taken_s     = 1'b1;
      redir_tgt_s = JT;
    end else if (branch) begin
      taken_s     = bne ? !eq_s : eq_s;
      redir_tgt_s = br_tgt_s;
    end else begin
      taken_s     = 1'b0;
      redir_tgt_s = 32'd0;
    end
  end

  // RUN/SQUASH next state; only RUN treats the incoming slot as live
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    live_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        live_s = 1'b1;
        if (taken_s) begin
          state_nxt_s = ST_SQUASH;
          cnt_nxt_s   = SQ_INIT;
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 2'd0;
        end
      end
      ST_SQUASH: begin
        cnt_nxt_s = cnt_r - 2'd1;
        if (cnt_r == 2'd1) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_SQUASH;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // FSM state and XM pipeline register; squashed slots lose their side effects
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      cnt_r       <= 2'd0;
      XM_MemtoReg <= 1'b0;
      XM_RegWrite <= 1'b0;
      XM_MemRead  <= 1'b0;
      XM_MemWrite <= 1'b0;
      ALUout      <= 32'd0;
      XM_MD       <= 32'd0;
      XM_RD       <= 5'd0;
      redirect    <= 1'b0;
      target      <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      XM_MemtoReg <= live_s & MemtoReg;
      XM_RegWrite <= live_s & RegWrite;
      XM_MemRead  <= live_s & MemRead;
      XM_MemWrite <= live_s & MemWrite;
      ALUout      <= alu_res_s;
      XM_MD       <= MD;
      XM_RD       <= RD;
      redirect    <= live_s & taken_s;
      if (live_s && taken_s) begin
        target <= redir_tgt_s;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, ALU ops, branch/jump
// redirect with squash, and reset in the middle of a squash.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        MemtoReg, RegWrite, MemRead, MemWrite;
  logic        branch, bne, jump;
  logic [2:0]  ALUctr;
  logic [31:0] JT, NPC, A, B, MD;
  logic [15:0] imm;
  logic [4:0]  RD;
  logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
  logic [31:0] ALUout, XM_MD, target;
  logic [4:0]  XM_RD;
  logic        redirect;

  int n_checks;
  int n_fail;

  execute_stage #(.SQUASH_CNT(2)) dut (
    .clk(clk), .rst(rst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .branch(branch), .bne(bne), .jump(jump), .ALUctr(ALUctr),
    .JT(JT), .NPC(NPC), .A(A), .B(B), .imm(imm), .MD(MD), .RD(RD),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
    .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
    .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
    .redirect(redirect), .target(target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nop();
    MemtoReg = 1'b0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    branch = 1'b0; bne = 1'b0; jump = 1'b0; ALUctr = 3'd0;
    JT = 32'd0; NPC = 32'd0; A = 32'd0; B = 32'd0; imm = 16'd0; MD = 32'd0; RD = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nop();
    rst = 1'b1;
    RegWrite = 1'b1; MemWrite = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1;
    A = 32'd5; B = 32'd7; MD = 32'h1234; RD = 5'd9; jump = 1'b1; JT = 32'h400;
    tick();
    tick();
    n_checks++;
    if ({XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, redirect} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, redirect});
    end
    n_checks++;
    if ({ALUout, XM_MD, XM_RD, target} !== 101'd0) begin
      n_fail++;
      $display("FAIL reset_data: ALUout=%h MD=%h RD=%0d target=%h want all 0",
               ALUout, XM_MD, XM_RD, target);
    end
    rst = 1'b0;
    nop();
    tick();
  endtask

  task automatic test_alu_arith();
    nop(); A = 32'd5; B = 32'd7; RD = 5'd3; RegWrite = 1'b1; ALUctr = 3'd0;
    tick();
    n_checks++;
    if (ALUout !== 32'd12) begin n_fail++; $display("FAIL add: got %h want 0000000c", ALUout); end
    n_checks++;
    if (XM_RD !== 5'd3 || XM_RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL add_ctrl: RD=%0d RegWrite=%b want 3 1", XM_RD, XM_RegWrite);
    end
    ALUctr = 3'd1;
    tick();
    n_checks++;
    if (ALUout !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub: got %h want fffffffe", ALUout); end
  endtask

  task automatic test_alu_logic();
    nop(); A = 32'hFFFF_FFFF; B = 32'd1; ALUctr = 3'd4;
    tick();
    n_checks++;
    if (ALUout !== 32'd1) begin n_fail++; $display("FAIL slt_neg: got %h want 1", ALUout); end
    A = 32'd1; B = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if (ALUout !== 32'd0) begin n_fail++; $display("FAIL slt_pos: got %h want 0", ALUout); end
    A = 32'h0000_F0F0; B = 32'h0000_0FF0; ALUctr = 3'd2;
    tick();
    n_checks++;
    if (ALUout !== 32'h0000_00F0) begin n_fail++; $display("FAIL and: got %h want 000000f0", ALUout); end
    ALUctr = 3'd3;
    tick();
    n_checks++;
    if (ALUout !== 32'h0000_FFF0) begin n_fail++; $display("FAIL or: got %h want 0000fff0", ALUout); end
    ALUctr = 3'd6;
    tick();
    n_checks++;
    if (ALUout !== 32'd0) begin n_fail++; $display("FAIL alu_6: got %h want 0", ALUout); end
  endtask

  task automatic test_branch_squash();
    nop(); branch = 1'b1; A = 32'd9; B = 32'd9; NPC = 32'h100; imm = 16'hFFFF;
    tick();
    n_checks++;
    if (redirect !== 1'b1 || target !== 32'h0000_00FC) begin
      n_fail++; $display("FAIL beq_taken: redirect=%b target=%h want 1 000000fc", redirect, target);
    end
    nop(); RegWrite = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RD = 5'd4;
    tick();
    n_checks++;
    if ({XM_RegWrite, XM_MemRead, XM_MemtoReg, redirect} !== 4'b0) begin
      n_fail++; $display("FAIL squash_lw: got %b want 0000",
                         {XM_RegWrite, XM_MemRead, XM_MemtoReg, redirect});
    end
    nop(); MemWrite = 1'b1; MD = 32'hCAFE;
    tick();
    n_checks++;
    if (XM_MemWrite !== 1'b0 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL squash_sw: MemWrite=%b redirect=%b want 0 0", XM_MemWrite, redirect);
    end
    tick();
    n_checks++;
    if (XM_MemWrite !== 1'b1 || XM_MD !== 32'hCAFE) begin
      n_fail++; $display("FAIL third_live: MemWrite=%b MD=%h want 1 0000cafe", XM_MemWrite, XM_MD);
    end
  endtask

  task automatic test_bne_jump();
    nop(); branch = 1'b1; bne = 1'b1; A = 32'd3; B = 32'd3; NPC = 32'h200;
    tick();
    n_checks++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL bne_equal: redirect=%b want 0", redirect); end
    nop(); MemWrite = 1'b1;
    tick();
    n_checks++;
    if (XM_MemWrite !== 1'b1) begin n_fail++; $display("FAIL after_bne: MemWrite=%b want 1", XM_MemWrite); end
    nop(); branch = 1'b1; bne = 1'b1; A = 32'd1; B = 32'd2; NPC = 32'h200; imm = 16'h0010;
    tick();
    n_checks++;
    if (redirect !== 1'b1 || target !== 32'h0000_0240) begin
      n_fail++; $display("FAIL bne_taken: redirect=%b target=%h want 1 00000240", redirect, target);
    end
    nop(); tick(); tick();
    // jump alongside a taken beq: the jump target must win
    nop(); jump = 1'b1; JT = 32'h400; branch = 1'b1; A = 32'd7; B = 32'd7; NPC = 32'h100; imm = 16'd1;
    tick();
    n_checks++;
    if (redirect !== 1'b1 || target !== 32'h0000_0400) begin
      n_fail++; $display("FAIL jump: redirect=%b target=%h want 1 00000400", redirect, target);
    end
    nop(); jump = 1'b1; JT = 32'h800;
    tick();
    n_checks++;
    if (redirect !== 1'b0) begin n_fail++; $display("FAIL jump_slot1: redirect=%b want 0", redirect); end
    nop();
    tick();
    n_checks++;
    if (redirect !== 1'b0 || target !== 32'h0000_0400) begin
      n_fail++; $display("FAIL jump_slot2: redirect=%b target=%h want 0 00000400", redirect, target);
    end
    MemWrite = 1'b1;
    tick();
    n_checks++;
    if (XM_MemWrite !== 1'b1 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL after_jump: MemWrite=%b redirect=%b want 1 0", XM_MemWrite, redirect);
    end
  endtask

  task automatic test_reset_mid_squash();
    nop(); branch = 1'b1; A = 32'd4; B = 32'd4; NPC = 32'h300;
    tick();
    n_checks++;
    if (redirect !== 1'b1) begin n_fail++; $display("FAIL pre_reset_br: redirect=%b want 1", redirect); end
    nop(); rst = 1'b1; MemWrite = 1'b1; A = 32'd8; B = 32'd8;
    tick();
    n_checks++;
    if ({XM_MemWrite, redirect} !== 2'b0 || ALUout !== 32'd0 || target !== 32'd0) begin
      n_fail++; $display("FAIL mid_squash_rst: MemWrite=%b redirect=%b ALUout=%h target=%h want 0 0 0 0",
                         XM_MemWrite, redirect, ALUout, target);
    end
    rst = 1'b0;
    nop(); MemWrite = 1'b1; RegWrite = 1'b1; RD = 5'd7;
    tick();
    n_checks++;
    if (XM_MemWrite !== 1'b1 || XM_RegWrite !== 1'b1 || XM_RD !== 5'd7) begin
      n_fail++; $display("FAIL post_reset_live: MemWrite=%b RegWrite=%b RD=%0d want 1 1 7",
                         XM_MemWrite, XM_RegWrite, XM_RD);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    nop();
    test_reset();
    test_alu_arith();
    test_alu_logic();
    test_branch_squash();
    test_bne_jump();
    test_reset_mid_squash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
